// File: rtl/lisp_memory.sv
// lisp_memory: append-only heap cell store.
// Writes allocate from free_ptr; reads are registered, addr 0 is nil.
module lisp_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [ADDR_WIDTH-1:0] write_result_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0]   free_ptr_q, free_ptr_d;
  logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  full;
  logic                  do_write;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // Allocation decision and next pointer / result address.
  always_comb begin
    full       = free_ptr_q[ADDR_WIDTH];
    wr_addr    = free_ptr_q[ADDR_WIDTH-1:0];
    do_write   = write_enable && !full;
    free_ptr_d = free_ptr_q;
    res_addr_d = res_addr_q;
    unique case (1'b1)
      do_write: begin
        free_ptr_d = free_ptr_q + 1'b1;
        res_addr_d = wr_addr;
      end
      (write_enable && full): begin
        res_addr_d = '0;
      end
      default: ;
    endcase
  end

  // Pointer and result address; a full heap pins the pointer at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_ptr_q <= (ADDR_WIDTH+1)'(1);
      res_addr_q <= '0;
    end else begin
      free_ptr_q <= free_ptr_d;
      res_addr_q <= res_addr_d;
    end
  end

  // Cell array write port; address 0 is never reached by free_ptr.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= write_data;
    end
  end

  // Registered read, old contents on a same-cycle write; nil reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      ready_q <= req;
      if (req) begin
        data_q <= (addr_in == '0) ? '0 : mem[addr_in];
      end
    end
  end

  assign data_ready        = ready_q;
  assign data_out          = data_q;
  assign write_result_addr = res_addr_q;

endmodule

// File: tb/tb_lisp_memory.sv
// tb_lisp_memory: directed vectors for lisp_memory.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_lisp_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [11:0] addr_in;
  logic        data_ready;
  logic [15:0] data_out;
  logic        write_enable;
  logic [15:0] write_data;
  logic [11:0] write_result_addr;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lisp_memory dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req),
    .addr_in           (addr_in),
    .data_ready        (data_ready),
    .data_out          (data_out),
    .write_enable      (write_enable),
    .write_data        (write_data),
    .write_result_addr (write_result_addr)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] rd_exp [3];

  initial begin
    rd_exp[0] = 16'hBEEF;
    rd_exp[1] = 16'hDEAD;
    rd_exp[2] = 16'hDEF0;

    rst_n        = 1'b0;
    req          = 1'b0;
    addr_in      = '0;
    write_enable = 1'b0;
    write_data   = '0;
    #13;
    check("rst_ready", 32'(data_ready), 32'd0);
    check("rst_data",  32'(data_out), 32'd0);
    check("rst_waddr", 32'(write_result_addr), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(data_ready), 32'd0);
    check("idle_waddr", 32'(write_result_addr), 32'd0);

    // sequential writes
    write_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      write_data = rd_exp[i];
      tick();
      check("seq_waddr", 32'(write_result_addr), 32'(i + 1));
    end
    write_enable = 1'b0;
    tick();
    check("hold_waddr", 32'(write_result_addr), 32'd3);

    // read-back, one-cycle strobes, data holds
    for (int i = 0; i < 3; i++) begin
      req     = 1'b1;
      addr_in = 12'(i + 1);
      tick();
      check("rd_data",  32'(data_out), 32'(rd_exp[i]));
      check("rd_ready", 32'(data_ready), 32'd1);
      req = 1'b0;
      tick();
      check("rd_drop",  32'(data_ready), 32'd0);
      check("rd_hold",  32'(data_out), 32'(rd_exp[i]));
    end

    // nil read
    req     = 1'b1;
    addr_in = 12'h000;
    tick();
    check("nil_data",  32'(data_out), 32'd0);
    check("nil_ready", 32'(data_ready), 32'd1);

    // back-to-back reads
    addr_in = 12'h001;
    tick();
    check("b2b_data0",  32'(data_out), 32'hBEEF);
    check("b2b_ready0", 32'(data_ready), 32'd1);
    addr_in = 12'h003;
    tick();
    check("b2b_data1",  32'(data_out), 32'hDEF0);
    check("b2b_ready1", 32'(data_ready), 32'd1);
    req = 1'b0;
    tick();
    check("b2b_drop", 32'(data_ready), 32'd0);

    // simultaneous write to 4 and read of 2
    write_enable = 1'b1;
    write_data   = 16'h1234;
    req          = 1'b1;
    addr_in      = 12'h002;
    tick();
    check("sim_data",  32'(data_out), 32'hDEAD);
    check("sim_waddr", 32'(write_result_addr), 32'd4);
    write_enable = 1'b0;
    addr_in      = 12'h004;
    tick();
    check("sim_rd4", 32'(data_out), 32'h1234);
    req = 1'b0;
    tick();

    // fill the heap: addresses 5..4094 get their own index
    write_enable = 1'b1;
    for (int i = 5; i < 4095; i++) begin
      write_data = 16'(i);
      tick();
    end
    check("fill_waddr", 32'(write_result_addr), 32'd4094);
    write_data = 16'hA5A5;
    tick();
    check("last_waddr", 32'(write_result_addr), 32'hFFF);
    write_data = 16'h5A5A;
    tick();
    check("full_waddr", 32'(write_result_addr), 32'd0);
    tick();
    check("full_again", 32'(write_result_addr), 32'd0);
    write_enable = 1'b0;
    req          = 1'b1;
    addr_in      = 12'hFFF;
    tick();
    check("full_keep", 32'(data_out), 32'hA5A5);
    addr_in = 12'h800;
    tick();
    check("fill_mid", 32'(data_out), 32'h0800);
    req = 1'b0;
    tick();

    // reset mid-burst
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    write_enable = 1'b1;
    write_data   = 16'h1111;
    tick();
    check("burst_w1", 32'(write_result_addr), 32'd1);
    write_data = 16'h2222;
    req        = 1'b1;
    addr_in    = 12'h800;
    tick();
    check("burst_w2", 32'(write_result_addr), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_ready", 32'(data_ready), 32'd0);
    check("mrst_data",  32'(data_out), 32'd0);
    check("mrst_waddr", 32'(write_result_addr), 32'd0);
    write_enable = 1'b0;
    req          = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    write_enable = 1'b1;
    write_data   = 16'h7777;
    tick();
    check("post_w1", 32'(write_result_addr), 32'd1);
    write_enable = 1'b0;
    req          = 1'b1;
    addr_in      = 12'h001;
    tick();
    check("post_rd1", 32'(data_out), 32'h7777);
    check("post_rdy", 32'(data_ready), 32'd1);
    req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
